// File: rtl/ifetch_queue_if.sv
// Fetch-queue bus: I-memory request/acknowledge, redirect input and decode-side head port.
// The slave modport is the queue's view; the master modport is the surrounding core's view.
interface ifetch_queue_if #(
  parameter int unsigned DEPTH = 4
);
  localparam int unsigned CW = $clog2(DEPTH) + 1;

  logic          InstrMemAck;
  logic [31:0]   Instruction;
  logic [31:0]   PCForInstrMem;
  logic          InstrMemReadEnable;
  logic          Redirect;
  logic [31:0]   RedirectPC;
  logic          Consume;
  logic          Valid;
  logic [31:0]   InstrOut;
  logic [31:0]   PCOut;
  logic [CW-1:0] Count;

  modport slave (
    input  InstrMemAck, Instruction, Redirect, RedirectPC, Consume,
    output PCForInstrMem, InstrMemReadEnable, Valid, InstrOut, PCOut, Count
  );

  modport master (
    output InstrMemAck, Instruction, Redirect, RedirectPC, Consume,
    input  PCForInstrMem, InstrMemReadEnable, Valid, InstrOut, PCOut, Count
  );
endinterface

// File: rtl/ifetch_queue.sv
// Instruction fetch queue: a single-outstanding I-memory fetcher feeding a circular
// {PC, instruction} buffer, with a DISCARD state that drops the reply of a redirected fetch.
module ifetch_queue #(
  parameter int unsigned DEPTH  = 4,
  parameter logic [31:0] INIT   = 32'h0000_0000,
  parameter logic [31:0] PCIncr = 32'd4
) (
  input logic           CLK,
  input logic           RST,
  ifetch_queue_if.slave bus
);
  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned CW = AW + 1;

  typedef enum logic {FETCH, DISCARD} state_t;

  state_t        r_state;
  state_t        w_state_nxt;
  logic [31:0]   r_fetch_pc;
  logic [31:0]   r_pend_pc;
  logic [31:0]   w_fetch_pc_nxt;
  logic [31:0]   w_pend_pc_nxt;
  logic [AW-1:0] r_wr_ptr;
  logic [AW-1:0] r_rd_ptr;
  logic [CW-1:0] r_count;
  logic [31:0]   r_pc_mem  [DEPTH];
  logic [31:0]   r_ins_mem [DEPTH];

  logic w_req;
  logic w_valid;
  logic w_push;
  logic w_pop;
  logic w_flush;

  always_ff @(posedge CLK) begin
    if (RST) r_state <= FETCH;
    else     r_state <= w_state_nxt;
  end

  // A raised request can only be satisfied by an Ack: Count never grows without one,
  // and a redirect during an open request parks the new target in DISCARD.
  always_comb begin
    w_state_nxt    = r_state;
    w_fetch_pc_nxt = r_fetch_pc;
    w_pend_pc_nxt  = r_pend_pc;
    w_req          = 1'b0;
    w_push         = 1'b0;
    w_pop          = 1'b0;
    w_flush        = 1'b0;
    w_valid        = (r_count != '0);
    case (r_state)
      FETCH: begin
        w_req = (r_count < CW'(DEPTH));
        if (bus.Redirect) begin
          w_flush = 1'b1;
          if (w_req && !bus.InstrMemAck) begin
            w_pend_pc_nxt = bus.RedirectPC;
            w_state_nxt   = DISCARD;
          end else begin
            w_fetch_pc_nxt = bus.RedirectPC;
          end
        end else begin
          w_pop = bus.Consume && w_valid;
          if (w_req && bus.InstrMemAck) begin
            w_push         = 1'b1;
            w_fetch_pc_nxt = r_fetch_pc + PCIncr;
          end
        end
      end
      DISCARD: begin
        w_req   = 1'b1;
        w_flush = bus.Redirect;
        if (bus.InstrMemAck) begin
          w_fetch_pc_nxt = bus.Redirect ? bus.RedirectPC : r_pend_pc;
          w_state_nxt    = FETCH;
        end else if (bus.Redirect) begin
          w_pend_pc_nxt = bus.RedirectPC;
        end
      end
    endcase
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      r_fetch_pc <= INIT;
      r_pend_pc  <= '0;
      r_wr_ptr   <= '0;
      r_rd_ptr   <= '0;
      r_count    <= '0;
    end else begin
      r_fetch_pc <= w_fetch_pc_nxt;
      r_pend_pc  <= w_pend_pc_nxt;
      if (w_flush) begin
        r_wr_ptr <= '0;
        r_rd_ptr <= '0;
        r_count  <= '0;
      end else begin
        if (w_push) begin
          r_pc_mem[r_wr_ptr]  <= r_fetch_pc;
          r_ins_mem[r_wr_ptr] <= bus.Instruction;
          r_wr_ptr            <= r_wr_ptr + AW'(1);
        end
        if (w_pop) r_rd_ptr <= r_rd_ptr + AW'(1);
        r_count <= r_count + CW'(w_push) - CW'(w_pop);
      end
    end
  end

  assign bus.InstrMemReadEnable = w_req && !RST;
  assign bus.PCForInstrMem      = r_fetch_pc;
  assign bus.Valid              = w_valid && !RST;
  assign bus.InstrOut           = bus.Valid ? r_ins_mem[r_rd_ptr] : '0;
  assign bus.PCOut              = bus.Valid ? r_pc_mem[r_rd_ptr]  : '0;
  assign bus.Count              = r_count;
endmodule

// File: tb/tb_ifetch_queue.sv
// Self-checking bench for ifetch_queue: directed scenarios followed by random traffic,
// every cycle compared against a queue-based reference model.
module tb_ifetch_queue;
  localparam int unsigned DEPTH = 4;
  localparam logic [31:0] INIT  = 32'h0000_0000;

  logic CLK;
  logic RST;
  int   n_tests;
  int   n_fail;

  logic [63:0] mq[$];
  logic [31:0] m_fpc;
  logic [31:0] m_pend;
  bit          m_disc;

  ifetch_queue_if #(.DEPTH(DEPTH)) bus();

  ifetch_queue #(.DEPTH(DEPTH), .INIT(INIT), .PCIncr(32'd4)) dut (
    .CLK (CLK),
    .RST (RST),
    .bus (bus)
  );

  initial begin
    CLK = 1'b0;
    forever #5 CLK = ~CLK;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  function automatic bit model_req(input bit rst);
    return !rst && (m_disc || mq.size() < DEPTH);
  endfunction

  // Drive one cycle of inputs, compare outputs with the model, then advance model and clock.
  task automatic step(input bit rst, input bit ack, input logic [31:0] ins,
                      input bit redir, input logic [31:0] rpc, input bit cons);
    bit req;
    bit vld;
    RST              = rst;
    bus.InstrMemAck  = ack;
    bus.Instruction  = ins;
    bus.Redirect     = redir;
    bus.RedirectPC   = rpc;
    bus.Consume      = cons;
    #1;
    req = model_req(rst);
    vld = !rst && (mq.size() > 0);
    chk("read_enable", 32'(bus.InstrMemReadEnable), 32'(req));
    if (req) chk("req_pc", bus.PCForInstrMem, m_fpc);
    chk("valid", 32'(bus.Valid), 32'(vld));
    chk("instr_out", bus.InstrOut, vld ? mq[0][31:0] : 32'h0);
    chk("pc_out", bus.PCOut, vld ? mq[0][63:32] : 32'h0);
    if (!rst) chk("count", 32'(bus.Count), mq.size());
    if (rst) begin
      mq.delete();
      m_fpc  = INIT;
      m_pend = '0;
      m_disc = 1'b0;
    end else if (m_disc) begin
      if (ack) begin
        m_fpc  = redir ? rpc : m_pend;
        m_disc = 1'b0;
      end else if (redir) begin
        m_pend = rpc;
      end
    end else if (redir) begin
      mq.delete();
      if (req && !ack) begin
        m_pend = rpc;
        m_disc = 1'b1;
      end else begin
        m_fpc = rpc;
      end
    end else begin
      if (cons && mq.size() > 0) void'(mq.pop_front());
      if (req && ack) begin
        mq.push_back({m_fpc, ins});
        m_fpc = m_fpc + 32'd4;
      end
    end
    @(posedge CLK);
    #1;
  endtask

  initial begin
    bit rst;
    bit ack;
    bit redir;
    n_tests = 0;
    n_fail  = 0;
    mq.delete();
    m_fpc  = INIT;
    m_pend = '0;
    m_disc = 1'b0;

    step(1, 1, 32'hFFFF_FFFF, 1, 32'h1234, 1);
    step(1, 0, 0, 0, 0, 0);

    // Ack every second cycle with Consume held
    step(0, 0, 0, 0, 0, 1);
    step(0, 1, 32'h11, 0, 0, 1);
    chk("s1_pc0", bus.PCOut, 32'h0);
    chk("s1_ins0", bus.InstrOut, 32'h11);
    step(0, 0, 0, 0, 0, 1);
    step(0, 1, 32'h22, 0, 0, 1);
    chk("s1_pc1", bus.PCOut, 32'h4);
    chk("s1_ins1", bus.InstrOut, 32'h22);
    step(0, 0, 0, 0, 0, 1);
    step(0, 1, 32'h33, 0, 0, 1);
    chk("s1_pc2", bus.PCOut, 32'h8);
    chk("s1_ins2", bus.InstrOut, 32'h33);
    step(0, 0, 0, 0, 0, 1);
    chk("s1_empty", 32'(bus.Valid), 32'h0);

    // Fill to DEPTH, then one Consume buys exactly one more request
    step(1, 0, 0, 0, 0, 0);
    for (int i = 0; i < 4; i++) step(0, 1, 32'hA0 + 32'(i), 0, 0, 0);
    chk("s2_full", 32'(bus.Count), 32'd4);
    chk("s2_noreq", 32'(bus.InstrMemReadEnable), 32'h0);
    step(0, 0, 0, 0, 0, 0);
    step(0, 0, 0, 0, 0, 0);
    chk("s2_noreq_hold", 32'(bus.InstrMemReadEnable), 32'h0);
    step(0, 0, 0, 0, 0, 1);
    chk("s2_req_again", 32'(bus.InstrMemReadEnable), 32'h1);
    chk("s2_req_pc", bus.PCForInstrMem, 32'h10);
    step(0, 1, 32'hAA, 0, 0, 0);
    chk("s2_refull", 32'(bus.InstrMemReadEnable), 32'h0);
    step(0, 0, 0, 0, 0, 0);

    // Redirect with request outstanding at 0x8; stale reply must be dropped
    step(1, 0, 0, 0, 0, 0);
    step(0, 1, 32'h1, 0, 0, 0);
    step(0, 1, 32'h2, 0, 0, 0);
    chk("s3_out_pc", bus.PCForInstrMem, 32'h8);
    step(0, 0, 0, 1, 32'h100, 0);
    chk("s3_flushed", 32'(bus.Valid), 32'h0);
    chk("s3_old_pc", bus.PCForInstrMem, 32'h8);
    step(0, 0, 0, 0, 0, 0);
    step(0, 0, 0, 0, 0, 1);
    step(0, 1, 32'hDEAD, 0, 0, 0);
    chk("s3_dropped", bus.InstrOut, 32'h0);
    chk("s3_new_pc", bus.PCForInstrMem, 32'h100);
    step(0, 1, 32'h55, 0, 0, 0);
    chk("s3_head_pc", bus.PCOut, 32'h100);
    chk("s3_head_ins", bus.InstrOut, 32'h55);

    // Redirect coinciding with Ack
    step(0, 1, 32'h66, 1, 32'h200, 0);
    chk("s4_drop", 32'(bus.Valid), 32'h0);
    chk("s4_pc", bus.PCForInstrMem, 32'h200);

    // Repeated redirects while discarding: latest target wins
    step(0, 0, 0, 1, 32'h280, 0);
    step(0, 0, 0, 1, 32'h300, 0);
    step(0, 0, 0, 1, 32'h400, 0);
    step(0, 1, 32'hBAD, 0, 0, 0);
    chk("s5_pc", bus.PCForInstrMem, 32'h400);
    chk("s5_drop", 32'(bus.Valid), 32'h0);

    // Reset mid-operation
    for (int i = 0; i < 3; i++) step(0, 1, 32'hC0 + 32'(i), 0, 0, 0);
    chk("s6_count3", 32'(bus.Count), 32'd3);
    step(1, 1, 32'h77, 1, 32'h900, 1);
    chk("s6_count0", 32'(bus.Count), 32'd0);
    chk("s6_valid0", 32'(bus.Valid), 32'h0);
    chk("s6_ren0", 32'(bus.InstrMemReadEnable), 32'h0);
    RST = 1'b0;
    bus.InstrMemAck = 1'b0;
    bus.Redirect    = 1'b0;
    #1;
    chk("s6_ren_init", 32'(bus.InstrMemReadEnable), 32'h1);
    chk("s6_pc_init", bus.PCForInstrMem, INIT);

    // Random traffic against the model
    for (int i = 0; i < 600; i++) begin
      rst   = ($urandom % 64) == 0;
      redir = ($urandom % 8) == 0;
      ack   = model_req(rst) && ($urandom % 2 == 1);
      step(rst, ack, $urandom, redir, $urandom & 32'hFFFF_FFFC, ($urandom % 3) != 0);
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule

// File: doc/ifetch_queue.md
IFETCH_QUEUE -- requirements
Module: ifetch_queue

Interface
REQ-001 The block SHALL have parameter DEPTH, default 4, giving the queue entry count (power of two, >= 2).
REQ-002 The block SHALL have parameter INIT, default 32'h0000_0000, giving the fetch PC after reset.
REQ-003 The block SHALL have parameter PCIncr, default 4, giving the fetch PC increment per accepted instruction.
REQ-004 The block SHALL have port CLK, input, 1, the single clock; all state updates on its rising edge.
REQ-005 The block SHALL have port RST, input, 1, reset, synchronous and active-high.
REQ-006 The block SHALL have port InstrMemAck, input, 1, a one-cycle I-memory acknowledge; Instruction is valid in the same cycle.
REQ-007 The block SHALL have port Instruction, input, 32, the I-memory read data.
REQ-008 The block SHALL have port PCForInstrMem, output, 32, the request address.
REQ-009 The block SHALL have port InstrMemReadEnable, output, 1, the request strobe.
REQ-010 The block SHALL have port Redirect, input, 1, a branch/jump/exception redirect pulse.
REQ-011 The block SHALL have port RedirectPC, input, 32, the target address, sampled when Redirect=1.
REQ-012 The block SHALL have port Consume, input, 1, decode accepting the head entry.
REQ-013 The block SHALL have port Valid, output, 1, indicating the queue is non-empty.
REQ-014 The block SHALL have port InstrOut, output, 32, the head instruction (0 when Valid=0).
REQ-015 The block SHALL have port PCOut, output, 32, the head instruction's PC (0 when Valid=0).
REQ-016 The block SHALL have port Count, output, $clog2(DEPTH)+1, the number of occupied entries.

Function
REQ-017 The block SHALL hold a circular buffer of DEPTH {PC, instruction} entries with wrapping read/write pointers and registered Count.
REQ-018 The block SHALL implement a fetch FSM with states FETCH and DISCARD, plus registers FetchPC and PendingPC.
REQ-019 In FETCH, InstrMemReadEnable SHALL be 1 iff Count < DEPTH, and PCForInstrMem SHALL equal FetchPC; at most one request SHALL be outstanding.
REQ-020 While InstrMemReadEnable=1 and no Ack has arrived, PCForInstrMem SHALL stay stable; a request once raised SHALL NOT drop before its Ack, except under RST.
REQ-021 On an Ack in FETCH without Redirect, the block SHALL write {FetchPC, Instruction} at the tail and set FetchPC += PCIncr (mod 2^32); the entry SHALL be visible at the head (Valid=1) one cycle later.
REQ-022 On Consume with Valid=1, the block SHALL advance the head; Consume with Valid=0 SHALL be ignored.
REQ-023 On a simultaneous push and pop, Count SHALL be unchanged and both pointers SHALL advance.
REQ-024 When full (Count=DEPTH), no request SHALL issue; a Consume in that cycle SHALL allow a request in the next cycle.
REQ-025 On Redirect with no request outstanding, or with Ack in the same cycle: the queue SHALL empty (Count=0, Valid=0 next cycle), the Ack data SHALL be dropped, FetchPC SHALL load RedirectPC, and the state SHALL stay FETCH.
REQ-026 On Redirect with a request outstanding and no Ack: the queue SHALL empty, PendingPC SHALL load RedirectPC, and the state SHALL go to DISCARD.
REQ-027 In DISCARD, InstrMemReadEnable SHALL be 1 with the old FetchPC; on Ack, the data SHALL be dropped, FetchPC SHALL load PendingPC, and the state SHALL go to FETCH.
REQ-028 A further Redirect in DISCARD SHALL overwrite PendingPC (latest wins); a Redirect in DISCARD coinciding with Ack SHALL load its RedirectPC into FetchPC.
REQ-029 Redirect SHALL take priority over Consume and push in the same cycle.
REQ-030 Count SHALL never exceed DEPTH or underflow below 0.

Reset
REQ-031 When RST=1 at a clock edge, the block SHALL set state=FETCH, FetchPC=INIT, PendingPC=0, pointers=0, and Count=0, regardless of any operation in progress.
REQ-032 During RST=1, InstrMemReadEnable, Valid, InstrOut, and PCOut SHALL all be 0; Ack and Redirect SHALL be ignored.
REQ-033 In the first cycle after RST falls, InstrMemReadEnable SHALL be 1 with PCForInstrMem=INIT.

Verification
REQ-034 Bench scenario: release reset; Ack every 2nd cycle with data 0x11,0x22,0x33; Consume held 1 -> PCOut 0,4,8 with InstrOut 0x11,0x22,0x33, each one cycle after its Ack.
REQ-035 Bench scenario: DEPTH=4, Consume=0, Ack every cycle -> Count reaches 4, InstrMemReadEnable=0 thereafter; one Consume -> exactly one more request at PC 0x10.
REQ-036 Bench scenario: request outstanding at PC 0x8, Redirect to 0x100, Ack 3 cycles later with 0xDEAD -> 0xDEAD never appears, next request is 0x100, Valid=0 until its Ack.
REQ-037 Bench scenario: Redirect to 0x200 in the same cycle as Ack -> data dropped, next PCForInstrMem=0x200.
REQ-038 Bench scenario: two Redirects (0x300 then 0x400) while in DISCARD -> fetch resumes at 0x400.
REQ-039 Bench scenario: assert RST with Count=3 and a request outstanding -> next cycle Count=0, Valid=0, InstrMemReadEnable=0; after release, request at INIT.
